// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Drives the core PLL reset, qualifies its lock output, and holds the core in
//   reset until lock has been continuously stable for LOCK_STABLE_CYCLES.
//   Any lock loss while running re-resets the PLL and the core.
//
//   Optional feature macro: PLL_LOCK_RETRY_EN
//     defined   -> a PLL that fails to lock within RELOCK_TIMEOUT cycles is
//                  reset again and retry_count (saturating at 15) increments.
//     undefined -> WAIT_LOCK waits indefinitely, retry_count is tied to 0.
//
// Ports
//   clk_74a      in   74.25 MHz reference clock (sole clock)
//   reset_n      in   synchronous active-low reset
//   pll_locked   in   PLL lock, asynchronous to clk_74a
//   pll_rst      out  PLL reset, active high
//   core_reset_n out  core reset, active low
//   lock_lost    out  one-cycle pulse on lock loss from RUN
//   retry_count  out  saturating count of timeout-triggered PLL resets
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RELOCK_TIMEOUT     = 1048576
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [1:0] ST_PLL_RESET   = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK   = 2'd1;
    localparam logic [1:0] ST_STABLE_WAIT = 2'd2;
    localparam logic [1:0] ST_RUN         = 2'd3;

    // Elaboration-time guard: every interval must be at least one cycle.
    if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || RELOCK_TIMEOUT < 1) begin : g_param_check
        $error("pll_lock_supervisor: cycle parameters must be >= 1");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [RST_W-1:0] rst_cnt;
    logic [RST_W-1:0] rst_cnt_nxt;
    logic [STB_W-1:0] stb_cnt;
    logic [STB_W-1:0] stb_cnt_nxt;
    logic             pll_rst_nxt;
    logic             core_reset_n_nxt;
    logic             lock_lost_nxt;

    logic sync_q1;
    logic locked_sync;

`ifdef PLL_LOCK_RETRY_EN
    localparam int unsigned TMO_W = $clog2(RELOCK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic [3:0]       retry_nxt;
`endif

    // Two-flop synchronizer; the only consumer of the raw pll_locked input.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            sync_q1     <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            sync_q1     <= pll_locked;
            locked_sync <= sync_q1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state        <= ST_PLL_RESET;
            rst_cnt      <= '0;
            stb_cnt      <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            lock_lost    <= 1'b0;
`ifdef PLL_LOCK_RETRY_EN
            tmo_cnt      <= '0;
            retry_count  <= 4'd0;
`endif
        end else begin
            state        <= state_nxt;
            rst_cnt      <= rst_cnt_nxt;
            stb_cnt      <= stb_cnt_nxt;
            pll_rst      <= pll_rst_nxt;
            core_reset_n <= core_reset_n_nxt;
            lock_lost    <= lock_lost_nxt;
`ifdef PLL_LOCK_RETRY_EN
            tmo_cnt      <= tmo_cnt_nxt;
            retry_count  <= retry_nxt;
`endif
        end
    end

`ifndef PLL_LOCK_RETRY_EN
    assign retry_count = 4'd0;
`endif

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        stb_cnt_nxt   = stb_cnt;
        lock_lost_nxt = 1'b0;
`ifdef PLL_LOCK_RETRY_EN
        tmo_cnt_nxt   = tmo_cnt;
        retry_nxt     = retry_count;
`endif

        case (state)
            ST_PLL_RESET: begin
                if (rst_cnt == RST_W'(PLL_RST_CYCLES - 1)) begin
                    state_nxt   = ST_WAIT_LOCK;
                    rst_cnt_nxt = '0;
`ifdef PLL_LOCK_RETRY_EN
                    tmo_cnt_nxt = '0;
`endif
                end else begin
                    rst_cnt_nxt = rst_cnt + RST_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_sync) begin
                    stb_cnt_nxt = STB_W'(1);
                    state_nxt   = (LOCK_STABLE_CYCLES == 1) ? ST_RUN : ST_STABLE_WAIT;
                end else begin
`ifdef PLL_LOCK_RETRY_EN
                    if (tmo_cnt == TMO_W'(RELOCK_TIMEOUT - 1)) begin
                        state_nxt   = ST_PLL_RESET;
                        rst_cnt_nxt = '0;
                        tmo_cnt_nxt = '0;
                        if (retry_count != 4'd15) begin
                            retry_nxt = retry_count + 4'd1;
                        end
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                    end
`endif
                end
            end

            ST_STABLE_WAIT: begin
                if (!locked_sync) begin
                    state_nxt   = ST_WAIT_LOCK;
                    stb_cnt_nxt = '0;
`ifdef PLL_LOCK_RETRY_EN
                    tmo_cnt_nxt = '0;
`endif
                end else if (stb_cnt == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_nxt   = ST_RUN;
                    stb_cnt_nxt = STB_W'(LOCK_STABLE_CYCLES);
                end else begin
                    stb_cnt_nxt = stb_cnt + STB_W'(1);
                end
            end

            ST_RUN: begin
                if (!locked_sync) begin
                    state_nxt     = ST_PLL_RESET;
                    lock_lost_nxt = 1'b1;
                    rst_cnt_nxt   = '0;
                    stb_cnt_nxt   = '0;
`ifdef PLL_LOCK_RETRY_EN
                    tmo_cnt_nxt   = '0;
`endif
                end
            end

            default: begin
                state_nxt   = ST_PLL_RESET;
                rst_cnt_nxt = '0;
                stb_cnt_nxt = '0;
            end
        endcase

        // Output levels follow the state being entered so they change on the transition edge.
        pll_rst_nxt      = (state_nxt == ST_PLL_RESET);
        core_reset_n_nxt = (state_nxt == ST_RUN);
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed bench for pll_lock_supervisor with PLL_RST_CYCLES=4,
//   LOCK_STABLE_CYCLES=8, RELOCK_TIMEOUT=32. Expected values are hand-derived
//   edge counts; retry expectations follow PLL_LOCK_RETRY_EN.
module tb_pll_lock_supervisor;

    localparam int unsigned PRC = 4;
    localparam int unsigned LSC = 8;
    localparam int unsigned RTO = 32;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_reset_n;
    logic       lock_lost;
    logic [3:0] retry_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk_74a = ~clk_74a;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .RELOCK_TIMEOUT     (RTO)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .lock_lost    (lock_lost),
        .retry_count  (retry_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Advance one active edge and settle before sampling.
    task automatic step();
        @(posedge clk_74a);
        #1;
    endtask

    // Release reset with lock low; pll_rst must stay high exactly PRC cycles.
    task automatic release_reset();
        reset_n = 1'b1;
        for (int e = 1; e <= int'(PRC); e++) begin
            step();
            check("rst_window_pll_rst", 32'(pll_rst), 32'(e < int'(PRC)));
            check("rst_window_core", 32'(core_reset_n), 32'(0));
        end
    endtask

    // Continuous lock from WAIT_LOCK: core released at edge 2+LSC.
    task automatic acquire();
        pll_locked = 1'b1;
        for (int e = 1; e <= int'(LSC) + 2; e++) begin
            step();
            check("acquire_core", 32'(core_reset_n), 32'(e >= int'(LSC) + 2));
            check("acquire_lock_lost", 32'(lock_lost), 32'(0));
        end
    endtask

    // Lock loss from RUN: reaction at edge 3, PLL reset pulse of PRC cycles.
    task automatic lose_lock();
        pll_locked = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check("loss_core", 32'(core_reset_n), 32'(e < 3));
            check("loss_pulse", 32'(lock_lost), 32'(e == 3));
            check("loss_pll_rst", 32'(pll_rst), 32'(e >= 3 && e < 3 + int'(PRC)));
            check("loss_retry", 32'(retry_count), 32'(0));
        end
    endtask

    initial begin
        int exp_rst;
        int exp_cnt;

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        repeat (3) step();
        check("reset_pll_rst", 32'(pll_rst), 32'(1));
        check("reset_core", 32'(core_reset_n), 32'(0));
        check("reset_lock_lost", 32'(lock_lost), 32'(0));
        check("reset_retry", 32'(retry_count), 32'(0));

        release_reset();
        acquire();
        lose_lock();

        // One-cycle dropout after 5 lock cycles restarts qualification.
        for (int e = 1; e <= 16; e++) begin
            pll_locked = (e != 6);
            step();
            check("dropout_core", 32'(core_reset_n), 32'(e >= 16));
            check("dropout_lock_lost", 32'(lock_lost), 32'(0));
        end

        // Re-enter STABLE_WAIT and reset at stable count 5 (edge 7 after lock).
        lose_lock();
        pll_locked = 1'b1;
        repeat (7) step();
        check("midcount_core", 32'(core_reset_n), 32'(0));
        reset_n = 1'b0;
        step();
        check("midreset_pll_rst", 32'(pll_rst), 32'(1));
        check("midreset_core", 32'(core_reset_n), 32'(0));
        check("midreset_retry", 32'(retry_count), 32'(0));
        check("midreset_lock_lost", 32'(lock_lost), 32'(0));
        pll_locked = 1'b0;
        step();
        release_reset();
        acquire();

        // Lock stuck low from reset release.
        reset_n = 1'b0;
        pll_locked = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        for (int e = 1; e <= 600; e++) begin
            step();
`ifdef PLL_LOCK_RETRY_EN
            exp_rst = int'(e < int'(PRC) ||
                      (e >= int'(PRC + RTO) && ((e - int'(PRC + RTO)) % int'(PRC + RTO)) < int'(PRC)));
            exp_cnt = e / int'(PRC + RTO);
            if (exp_cnt > 15) exp_cnt = 15;
`else
            exp_rst = int'(e < int'(PRC));
            exp_cnt = 0;
`endif
            check("stuck_pll_rst", 32'(pll_rst), 32'(exp_rst));
            check("stuck_retry", 32'(retry_count), 32'(exp_cnt));
            check("stuck_core", 32'(core_reset_n), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the core PLL: drives its reset input, watches its `locked` output, and generates the core-wide reset released only after lock has been continuously stable for a programmable interval. Sits directly upstream and downstream of the core PLL in `clk_74a`, the PLL's reference clock domain. On lock loss it re-resets the PLL and re-holds the core in reset. With retry enabled, a PLL that fails to lock in time is reset again.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized lock samples required before core reset release (≥1).
- `RELOCK_TIMEOUT`, 1048576: cycles allowed in WAIT_LOCK before a retry (≥1; used only with retry enabled).

Ports:
- `clk_74a`, input, 1: 74.25 MHz reference clock; sole clock.
- `reset_n`, input, 1: synchronous, active-low reset.
- `pll_locked`, input, 1: PLL lock, asynchronous to `clk_74a`.
- `pll_rst`, output, 1: PLL reset, active high.
- `core_reset_n`, output, 1: core reset, active low.
- `lock_lost`, output, 1: one-cycle pulse on lock loss from RUN.
- `retry_count`, output, 4: saturating count of timeout-triggered PLL resets.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`locked_sync`); no other logic samples the raw input.
- States: PLL_RESET, WAIT_LOCK, STABLE_WAIT, RUN. All outputs are registered.
- PLL_RESET: `pll_rst`=1, `core_reset_n`=0. Counts `PLL_RST_CYCLES` cycles, then goes to WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK: `pll_rst`=0, `core_reset_n`=0. Timeout counter increments each cycle.
  - `locked_sync`=1 moves to STABLE_WAIT, with the stable counter loaded to 1.
  - Timeout counter reaching `RELOCK_TIMEOUT` moves to PLL_RESET and increments `retry_count`, saturating at 15.
  - If both occur in the same cycle, lock wins.
- STABLE_WAIT: the stable counter increments on each `locked_sync`=1 cycle.
  - `locked_sync`=0 returns to WAIT_LOCK; the timeout counter restarts from 0.
  - Stable counter reaching `LOCK_STABLE_CYCLES` moves to RUN and sets `core_reset_n`=1 on that edge.
  - With `LOCK_STABLE_CYCLES`=1, the WAIT_LOCK lock edge goes directly to RUN.
- RUN: `core_reset_n`=1. `locked_sync`=0 moves to PLL_RESET, drives `core_reset_n`=0 and `lock_lost`=1 for exactly one cycle, and clears both counters. `retry_count` is not incremented.
- Counter widths are `$clog2(param+1)` bits, so there is no wrap-around.
- `reset_n` low at any state, including mid-count: next edge forces PLL_RESET, all counters 0, synchronizer flops 0, `retry_count`=0.

## Timing
- Reset values: `pll_rst`=1, `core_reset_n`=0, `lock_lost`=0, `retry_count`=0.
- After `reset_n` is sampled high, `pll_rst` stays high for exactly `PLL_RST_CYCLES` more edges.
- Lock acquire: take the edge that first samples `pll_locked`=1 as edge 1. With lock continuous, `core_reset_n` rises at edge 2+`LOCK_STABLE_CYCLES`.
- Lock loss in RUN: take the edge that first samples `pll_locked`=0 as edge 1. `core_reset_n` falls and `lock_lost` pulses at edge 3; `pll_rst` rises at edge 3.
- A lock dropout of one cycle or longer is always seen by the synchronizer and restarts qualification.

## Configuration
- `PLL_LOCK_RETRY_EN` defined: the WAIT_LOCK timeout and retry behaviour are active as described.
- Undefined: the timeout counter is not built, WAIT_LOCK waits indefinitely, `retry_count` is constant 0, and `RELOCK_TIMEOUT` is ignored.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `RELOCK_TIMEOUT`=32.
- Reset release, `pll_locked` held 0 → `pll_rst` high 4 cycles then low; `core_reset_n` stays 0.
- `pll_locked` rises after `pll_rst` falls and stays high → `core_reset_n` rises exactly at edge 10; `lock_lost` never pulses.
- `pll_locked` high 5 cycles, low 1, then high → no release at edge 10; `core_reset_n` rises 10 edges after the second rise.
- In RUN, `pll_locked` falls → `lock_lost` one-cycle pulse and `core_reset_n`=0 at edge 3; `pll_rst` high 4 cycles; `retry_count` stays 0.
- Retry enabled, `pll_locked` stuck 0 → `pll_rst` re-pulses every 36 cycles; `retry_count` = 1, 2, … saturating at 15 after the 15th retry. Retry disabled → single pulse, count 0.
- `reset_n` asserted mid-STABLE_WAIT at count 5 → next edge gives `pll_rst`=1, `core_reset_n`=0, `retry_count`=0; full sequence repeats.
